// File: rtl/sand_pkg.sv
// Shared types for the sand cellular-automaton engine: pixel/word geometry
// and the frame-scan controller state encoding.
package sand_pkg;

    localparam int WORD_W       = 16;
    localparam int PIX_PER_WORD = 8;

    typedef logic [1:0] pix_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_REG,
        S_RD_FLR,
        S_CAP,
        S_CALC,
        S_WR_FLR,
        S_WR_REG,
        S_DONE
    } scan_state_t;

endpackage

// File: rtl/sand_scan_ctrl.sv
// Frame-scan controller: walks the grid bottom-up, reading each region word and
// the floor word below it, and writing back the sand_update results.
module sand_scan_ctrl
    import sand_pkg::*;
#(
    parameter int WIDTH_WORDS = 80,
    parameter int HEIGHT      = 480,
    parameter int ADDR_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic              mem_gnt,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic              calc_en,
    output logic [WORD_W-1:0] region_out,
    output logic [WORD_W-1:0] floor_out,
    input  logic [WORD_W-1:0] new_region,
    input  logic [WORD_W-1:0] new_floor,
    output scan_state_t       dbg_state
);

    localparam logic [ADDR_W-1:0] ROW_W      = ADDR_W'(WIDTH_WORDS);
    localparam logic [ADDR_W-1:0] COL_LAST   = ADDR_W'(WIDTH_WORDS - 1);
    localparam logic [ADDR_W-1:0] ROW_START  = ADDR_W'(HEIGHT - 2);
    localparam logic [ADDR_W-1:0] BASE_START = ADDR_W'((HEIGHT - 2) * WIDTH_WORDS);

    scan_state_t       state_q;
    logic              dir_q;
    logic              first_q;
    logic [ADDR_W-1:0] row_q;
    logic [ADDR_W-1:0] col_q;
    logic [ADDR_W-1:0] base_q;
    logic              busy_q;
    logic              done_q;
    logic              mem_rd_q;
    logic              mem_wr_q;
    logic              calc_en_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [WORD_W-1:0] mem_wdata_q;
    logic [WORD_W-1:0] region_q;
    logic [WORD_W-1:0] floor_q;
    logic [WORD_W-1:0] res_region_q;
    logic [WORD_W-1:0] res_floor_q;

    logic [ADDR_W-1:0] first_col_d;
    logic [ADDR_W-1:0] col_step_d;
    logic [ADDR_W-1:0] base_up_d;
    logic [ADDR_W-1:0] reg_addr_d;
    logic [ADDR_W-1:0] flr_addr_d;
    logic              last_col_d;
    logic              last_row_d;

    // dir=1 scans right-to-left so alternate frames cancel horizontal drift.
    always_comb begin
        first_col_d = dir_q ? COL_LAST : '0;
        col_step_d  = dir_q ? (col_q - 1'b1) : (col_q + 1'b1);
        last_col_d  = dir_q ? (col_q == '0) : (col_q == COL_LAST);
        last_row_d  = (row_q == '0);
        base_up_d   = base_q - ROW_W;
        reg_addr_d  = base_q + col_q;
        flr_addr_d  = base_q + ROW_W + col_q;
    end

    // Outputs are registered: each transition loads the values the next state presents.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            dir_q        <= 1'b0;
            first_q      <= 1'b0;
            row_q        <= '0;
            col_q        <= '0;
            base_q       <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            mem_rd_q     <= 1'b0;
            mem_wr_q     <= 1'b0;
            calc_en_q    <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            region_q     <= '0;
            floor_q      <= '0;
            res_region_q <= '0;
            res_floor_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        row_q      <= ROW_START;
                        base_q     <= BASE_START;
                        col_q      <= first_col_d;
                        mem_addr_q <= BASE_START + first_col_d;
                        mem_rd_q   <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= S_RD_REG;
                    end
                end
                S_RD_REG: begin
                    if (mem_gnt) begin
                        mem_addr_q <= flr_addr_d;
                        first_q    <= 1'b1;
                        state_q    <= S_RD_FLR;
                    end
                end
                S_RD_FLR: begin
                    // Read data for the region word is valid only in the first cycle here.
                    first_q <= 1'b0;
                    if (first_q) begin
                        region_q <= mem_rdata;
                    end
                    if (mem_gnt) begin
                        mem_rd_q <= 1'b0;
                        state_q  <= S_CAP;
                    end
                end
                S_CAP: begin
                    floor_q   <= mem_rdata;
                    calc_en_q <= 1'b1;
                    state_q   <= S_CALC;
                end
                S_CALC: begin
                    res_region_q <= new_region;
                    res_floor_q  <= new_floor;
                    calc_en_q    <= 1'b0;
                    mem_wr_q     <= 1'b1;
                    mem_addr_q   <= flr_addr_d;
                    mem_wdata_q  <= new_floor;
                    state_q      <= S_WR_FLR;
                end
                S_WR_FLR: begin
                    if (mem_gnt) begin
                        mem_addr_q  <= reg_addr_d;
                        mem_wdata_q <= res_region_q;
                        state_q     <= S_WR_REG;
                    end
                end
                S_WR_REG: begin
                    if (mem_gnt) begin
                        mem_wr_q <= 1'b0;
                        if (last_col_d && last_row_d) begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else if (last_col_d) begin
                            row_q      <= row_q - 1'b1;
                            base_q     <= base_up_d;
                            col_q      <= first_col_d;
                            mem_addr_q <= base_up_d + first_col_d;
                            mem_rd_q   <= 1'b1;
                            state_q    <= S_RD_REG;
                        end else begin
                            col_q      <= col_step_d;
                            mem_addr_q <= base_q + col_step_d;
                            mem_rd_q   <= 1'b1;
                            state_q    <= S_RD_REG;
                        end
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    dir_q   <= ~dir_q;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign mem_addr   = mem_addr_q;
    assign mem_rd     = mem_rd_q;
    assign mem_wr     = mem_wr_q;
    assign mem_wdata  = mem_wdata_q;
    assign calc_en    = calc_en_q;
    assign region_out = region_q;
    assign floor_out  = floor_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_sand_scan_ctrl.sv
// Self-checking bench for sand_scan_ctrl: a RAM model with controllable grant,
// a stub sand_update, and a frame-level reference model of the scan.
module tb_sand_scan_ctrl;
    import sand_pkg::*;

    localparam int W     = 2;
    localparam int H     = 3;
    localparam int NW    = W * H;
    localparam int WORDS = W * (H - 1);

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        busy, done, mem_rd, mem_wr, calc_en;
    logic [15:0] mem_addr, mem_wdata, region_out, floor_out, new_region, new_floor;
    logic        mem_gnt = 1'b1;
    logic [15:0] mem_rdata = '0;
    scan_state_t dbg_state;

    logic        s_start = 1'b0;
    logic        s_busy, s_done, s_rd, s_wr, s_calc_en;
    logic [15:0] s_addr, s_wdata, s_region_out, s_floor_out, s_new_region, s_new_floor;
    logic        s_gnt = 1'b1;
    logic [15:0] s_rdata = '0;
    scan_state_t s_dbg_state;

    sand_scan_ctrl #(.WIDTH_WORDS(W), .HEIGHT(H), .ADDR_W(16)) u_dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rdata(mem_rdata), .calc_en(calc_en),
        .region_out(region_out), .floor_out(floor_out),
        .new_region(new_region), .new_floor(new_floor), .dbg_state(dbg_state)
    );

    sand_scan_ctrl #(.WIDTH_WORDS(1), .HEIGHT(2), .ADDR_W(16)) u_small (
        .clk(clk), .reset(reset), .start(s_start), .busy(s_busy), .done(s_done),
        .mem_addr(s_addr), .mem_rd(s_rd), .mem_wr(s_wr), .mem_wdata(s_wdata),
        .mem_gnt(s_gnt), .mem_rdata(s_rdata), .calc_en(s_calc_en),
        .region_out(s_region_out), .floor_out(s_floor_out),
        .new_region(s_new_region), .new_floor(s_new_floor), .dbg_state(s_dbg_state)
    );

    // Stub sand_update: region inverted, floor incremented.
    assign new_region   = region_out ^ 16'hFFFF;
    assign new_floor    = floor_out + 16'd1;
    assign s_new_region = s_region_out ^ 16'hFFFF;
    assign s_new_floor  = s_floor_out + 16'd1;

    always #5 clk = ~clk;

    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          gmode = 0;
    int          stall_left = 0;
    scan_state_t prev_state = S_IDLE;
    logic [15:0] tb_ram [NW];
    logic [15:0] ref_ram [NW];
    logic [32:0] exp_q[$];
    logic [32:0] act_q[$];
    logic [32:0] s_wq[$];
    bit          rd_pend = 0;
    logic [15:0] rd_addr = '0;
    bit          s_pend = 0;
    logic [15:0] s_paddr = '0;
    int          stall_cnt = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    bit          both_seen = 0;
    bit          hold_err = 0;
    bit          prev_stalled = 0;
    logic        prev_rd = 0, prev_wr = 0;
    logic [15:0] prev_addr = '0, prev_wdata = '0;
    bit          model_dir = 0;
    int          last_start = 0;

    always @(posedge clk) cyc++;

    // Grant and read-data drivers update just after the active edge.
    always @(posedge clk) begin
        #1;
        case (gmode)
            1: mem_gnt = ($urandom_range(0, 2) != 0);
            2: begin
                if (dbg_state != prev_state && (dbg_state == S_RD_FLR || dbg_state == S_WR_REG))
                    stall_left = 3;
                prev_state = dbg_state;
                mem_gnt = (stall_left == 0);
                if (stall_left > 0) stall_left--;
            end
            default: mem_gnt = 1'b1;
        endcase
        if (rd_pend) begin
            mem_rdata = (rd_addr < NW) ? tb_ram[rd_addr] : 16'hDEAD;
            rd_pend = 0;
        end else begin
            mem_rdata = 16'($urandom);
        end
        if (s_pend) begin
            s_rdata = (s_paddr == 16'd0) ? 16'h1234 : 16'h0F0F;
            s_pend = 0;
        end else begin
            s_rdata = 16'($urandom);
        end
    end

    // Bus monitor and RAM behaviour, sampled mid-cycle.
    always @(negedge clk) begin
        if (mem_rd && mem_gnt) begin
            act_q.push_back({1'b0, mem_addr, 16'h0000});
            rd_pend = 1;
            rd_addr = mem_addr;
        end
        if (mem_wr && mem_gnt) begin
            act_q.push_back({1'b1, mem_addr, mem_wdata});
            if (mem_addr < NW) tb_ram[mem_addr] = mem_wdata;
        end
        if ((mem_rd || mem_wr) && !mem_gnt) stall_cnt++;
        if (mem_rd && mem_wr) both_seen = 1;
        if (prev_stalled && (mem_rd !== prev_rd || mem_wr !== prev_wr || mem_addr !== prev_addr ||
                             (mem_wr && mem_wdata !== prev_wdata)))
            hold_err = 1;
        prev_stalled = (mem_rd || mem_wr) && !mem_gnt;
        prev_rd = mem_rd;
        prev_wr = mem_wr;
        prev_addr = mem_addr;
        prev_wdata = mem_wdata;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (s_rd && s_gnt) begin
            s_pend = 1;
            s_paddr = s_addr;
        end
        if (s_wr && s_gnt) s_wq.push_back({1'b1, s_addr, s_wdata});
    end

    // Reference: one full frame pass, bottom-up, column order set by direction.
    task automatic model_frame();
        int c, ra, fa;
        logic [15:0] nf, nr;
        exp_q.delete();
        for (int r = H - 2; r >= 0; r--) begin
            for (int k = 0; k < W; k++) begin
                c  = model_dir ? (W - 1 - k) : k;
                ra = r * W + c;
                fa = (r + 1) * W + c;
                nf = ref_ram[fa] + 16'd1;
                nr = ref_ram[ra] ^ 16'hFFFF;
                exp_q.push_back({1'b0, 16'(ra), 16'h0000});
                exp_q.push_back({1'b0, 16'(fa), 16'h0000});
                exp_q.push_back({1'b1, 16'(fa), nf});
                exp_q.push_back({1'b1, 16'(ra), nr});
                ref_ram[fa] = nf;
                ref_ram[ra] = nr;
            end
        end
        model_dir = !model_dir;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b expected 0", done); end
        n_cmp++; if (mem_rd !== 1'b0) begin n_bad++; $display("FAIL reset_rd: got %b expected 0", mem_rd); end
        n_cmp++; if (mem_wr !== 1'b0) begin n_bad++; $display("FAIL reset_wr: got %b expected 0", mem_wr); end
        n_cmp++; if (calc_en !== 1'b0) begin n_bad++; $display("FAIL reset_calc: got %b expected 0", calc_en); end
        n_cmp++; if (mem_addr !== 16'h0) begin n_bad++; $display("FAIL reset_addr: got %h expected 0", mem_addr); end
        n_cmp++; if (mem_wdata !== 16'h0) begin n_bad++; $display("FAIL reset_wdata: got %h expected 0", mem_wdata); end
        n_cmp++; if (region_out !== 16'h0) begin n_bad++; $display("FAIL reset_region: got %h expected 0", region_out); end
        n_cmp++; if (floor_out !== 16'h0) begin n_bad++; $display("FAIL reset_floor: got %h expected 0", floor_out); end
        n_cmp++; if (dbg_state !== S_IDLE) begin n_bad++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, S_IDLE); end
        @(negedge clk);
        reset = 0;
    endtask

    task automatic test_frame(input string name, input int gm);
        bit ok;
        model_frame();
        gmode = gm;
        act_q.delete();
        stall_cnt = 0; done_cnt = 0; both_seen = 0; hold_err = 0; prev_stalled = 0;
        prev_state = S_IDLE; stall_left = 0;
        @(negedge clk);
        start = 1;
        last_start = cyc;
        @(negedge clk);
        start = 0;
        ok = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            #1;
            if (done_cnt != 0) begin ok = 1; break; end
        end
        repeat (3) @(negedge clk);
        #1;
        gmode = 0;
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL %s_timeout: got no done expected done within 3000 cycles", name); end
        n_cmp++;
        if (act_q.size() !== exp_q.size()) begin
            n_bad++; $display("FAIL %s_txn_count: got %0d expected %0d", name, act_q.size(), exp_q.size());
        end
        for (int k = 0; k < exp_q.size() && k < act_q.size(); k++) begin
            n_cmp++;
            if (act_q[k] !== exp_q[k]) begin
                n_bad++; $display("FAIL %s_txn[%0d]: got %h expected %h", name, k, act_q[k], exp_q[k]);
            end
        end
        for (int k = 0; k < NW; k++) begin
            n_cmp++;
            if (tb_ram[k] !== ref_ram[k]) begin
                n_bad++; $display("FAIL %s_ram[%0d]: got %h expected %h", name, k, tb_ram[k], ref_ram[k]);
            end
        end
        n_cmp++;
        if (done_cyc !== last_start + 6 * WORDS + 1 + stall_cnt) begin
            n_bad++; $display("FAIL %s_done_cycle: got %0d expected %0d", name, done_cyc - last_start, 6 * WORDS + 1 + stall_cnt);
        end
        n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL %s_done_count: got %0d expected 1", name, done_cnt); end
        n_cmp++; if (both_seen !== 1'b0) begin n_bad++; $display("FAIL %s_rd_wr_both: got 1 expected 0", name); end
        n_cmp++; if (hold_err !== 1'b0) begin n_bad++; $display("FAIL %s_hold_stable: got 1 expected 0", name); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL %s_busy_after: got %b expected 0", name, busy); end
    endtask

    task automatic test_basic_values();
        n_cmp++;
        if (act_q.size() < 4) begin
            n_bad++; $display("FAIL basic_short: got %0d txns expected at least 4", act_q.size());
        end else begin
            n_cmp++;
            if (act_q[0] !== {1'b0, 16'd2, 16'h0000}) begin n_bad++; $display("FAIL basic_first_rd: got %h expected %h", act_q[0], {1'b0, 16'd2, 16'h0000}); end
            n_cmp++;
            if (act_q[2] !== {1'b1, 16'd4, 16'h0005}) begin n_bad++; $display("FAIL basic_floor_wr: got %h expected %h", act_q[2], {1'b1, 16'd4, 16'h0005}); end
            n_cmp++;
            if (act_q[3] !== {1'b1, 16'd2, 16'hFFFE}) begin n_bad++; $display("FAIL basic_region_wr: got %h expected %h", act_q[3], {1'b1, 16'd2, 16'hFFFE}); end
        end
    endtask

    task automatic test_reverse_order();
        n_cmp++;
        if (act_q.size() < 4) begin
            n_bad++; $display("FAIL reverse_short: got %0d txns expected at least 4", act_q.size());
        end else begin
            n_cmp++;
            if (act_q[0][31:16] !== 16'd3) begin n_bad++; $display("FAIL reverse_first: got %h expected 0003", act_q[0][31:16]); end
            n_cmp++;
            if (act_q[act_q.size() - 1][32:16] !== {1'b1, 16'd0}) begin
                n_bad++; $display("FAIL reverse_last: got %h expected write to 0000", act_q[act_q.size() - 1][32:16]);
            end
        end
    endtask

    task automatic test_stall_delay();
        n_cmp++;
        if (done_cyc - last_start !== 12 * WORDS + 1) begin
            n_bad++; $display("FAIL stall_delay: got %0d expected %0d", done_cyc - last_start, 12 * WORDS + 1);
        end
    endtask

    task automatic test_start_busy();
        int n;
        model_frame();
        gmode = 0;
        act_q.delete();
        done_cnt = 0;
        @(negedge clk);
        start = 1;
        n = cyc;
        while (cyc <= n + 6 * WORDS + 1) begin
            @(negedge clk);
            start = (cyc == n + 6 * WORDS + 1) || ($urandom_range(0, 3) == 0);
        end
        @(negedge clk);
        start = 0;
        repeat (10) @(negedge clk);
        #1;
        n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL busy_start_done_count: got %0d expected 1", done_cnt); end
        n_cmp++; if (done_cyc !== n + 6 * WORDS + 1) begin n_bad++; $display("FAIL busy_start_done_cycle: got %0d expected %0d", done_cyc - n, 6 * WORDS + 1); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL busy_start_idle: got %b expected 0", busy); end
        n_cmp++; if (act_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL busy_start_txns: got %0d expected %0d", act_q.size(), exp_q.size()); end
    endtask

    task automatic test_reset_mid();
        bit found;
        gmode = 0;
        @(negedge clk);
        start = 1;
        @(negedge clk);
        start = 0;
        found = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            #1;
            if (dbg_state == S_WR_FLR) begin found = 1; break; end
        end
        n_cmp++;
        if (!found) begin n_bad++; $display("FAIL rstmid_timeout: got no WR_FLR expected WR_FLR within 50 cycles"); end
        reset = 1;
        @(negedge clk);
        #1;
        n_cmp++; if (mem_wr !== 1'b0) begin n_bad++; $display("FAIL rstmid_wr: got %b expected 0", mem_wr); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
        n_cmp++; if (mem_rd !== 1'b0) begin n_bad++; $display("FAIL rstmid_rd: got %b expected 0", mem_rd); end
        n_cmp++; if (mem_addr !== 16'h0) begin n_bad++; $display("FAIL rstmid_addr: got %h expected 0", mem_addr); end
        n_cmp++; if (mem_wdata !== 16'h0) begin n_bad++; $display("FAIL rstmid_wdata: got %h expected 0", mem_wdata); end
        n_cmp++; if (region_out !== 16'h0) begin n_bad++; $display("FAIL rstmid_region: got %h expected 0", region_out); end
        n_cmp++; if (dbg_state !== S_IDLE) begin n_bad++; $display("FAIL rstmid_state: got %0d expected %0d", dbg_state, S_IDLE); end
        reset = 0;
        for (int k = 0; k < NW; k++) ref_ram[k] = tb_ram[k];
        model_dir = 0;
    endtask

    task automatic test_small();
        int  n;
        bit  exp_busy, exp_done;
        s_wq.delete();
        @(negedge clk);
        s_start = 1;
        n = cyc;
        #1;
        n_cmp++; if (s_busy !== 1'b0) begin n_bad++; $display("FAIL small_busy_at_start: got %b expected 0", s_busy); end
        @(negedge clk);
        s_start = 0;
        for (int k = 1; k <= 9; k++) begin
            if (k > 1) @(negedge clk);
            #1;
            exp_busy = (cyc - n >= 1) && (cyc - n <= 7);
            exp_done = (cyc - n == 7);
            n_cmp++;
            if (s_busy !== exp_busy) begin n_bad++; $display("FAIL small_busy_c%0d: got %b expected %b", cyc - n, s_busy, exp_busy); end
            n_cmp++;
            if (s_done !== exp_done) begin n_bad++; $display("FAIL small_done_c%0d: got %b expected %b", cyc - n, s_done, exp_done); end
        end
        n_cmp++;
        if (s_wq.size() !== 2) begin
            n_bad++; $display("FAIL small_wr_count: got %0d expected 2", s_wq.size());
        end else begin
            n_cmp++;
            if (s_wq[0] !== {1'b1, 16'd1, 16'h0F10}) begin n_bad++; $display("FAIL small_floor_wr: got %h expected %h", s_wq[0], {1'b1, 16'd1, 16'h0F10}); end
            n_cmp++;
            if (s_wq[1] !== {1'b1, 16'd0, 16'hEDCB}) begin n_bad++; $display("FAIL small_region_wr: got %h expected %h", s_wq[1], {1'b1, 16'd0, 16'hEDCB}); end
        end
    endtask

    initial begin
        for (int k = 0; k < NW; k++) tb_ram[k] = 16'($urandom);
        tb_ram[2] = 16'h0001;
        tb_ram[4] = 16'h0004;
        for (int k = 0; k < NW; k++) ref_ram[k] = tb_ram[k];

        test_reset();
        test_frame("basic", 0);
        test_basic_values();
        test_frame("reverse", 0);
        test_reverse_order();
        test_frame("stall", 2);
        test_stall_delay();
        test_frame("rand_a", 1);
        test_frame("rand_b", 1);
        test_start_busy();
        test_reset_mid();
        test_frame("after_reset", 0);
        test_small();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
